// File: rtl/psum_writeback_ctrl.sv
// Read-modify-write sequencer for one PSUM SRAM row per output row: pops OFIFO,
// reads the PSUM word, drives the shared SFP control and writes the SFP result back.
module psum_writeback_ctrl #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11,
  parameter int unsigned len_bw  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [len_bw-1:0]        num_rows,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_a,
  output logic [col*psum_bw-1:0]   sram_d,
  output logic                     sfp_accum,
  output logic                     sfp_passthrough,
  output logic [1:0]               sfp_actfunc,
  input  logic [col*psum_bw-1:0]   sfp_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned row_bw = col * psum_bw;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           mode_r;
  logic [addr_bw-1:0]   base_r;
  logic [len_bw-1:0]    num_rows_r;
  logic [len_bw-1:0]    cnt;

  logic                 accept_c;
  logic                 needs_fifo_c;
  logic                 issue_go_c;
  logic                 last_row_c;

  assign accept_c     = (state == IDLE) && start;
  assign needs_fifo_c = (mode_r == 2'd0) || (mode_r == 2'd3);
  assign issue_go_c   = !needs_fifo_c || ofifo_valid;
  assign last_row_c   = (cnt == (num_rows_r - len_bw'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_rows == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_go_c) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = WRITE;
      WRITE:   state_nxt = last_row_c ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes and OFIFO pop; the ISSUE stall has to react to ofifo_valid in the same cycle
  always_comb begin
    ofifo_rd = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    case (state)
      ISSUE: begin
        if (issue_go_c) begin
          sram_cen = 1'b0;
          ofifo_rd = needs_fifo_c;
        end
      end
      WRITE: begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
      end
      default: begin
        sram_cen = 1'b1;
      end
    endcase
  end

  // Pass context, row counter, address, captured row and SFP control
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r          <= 2'd0;
      base_r          <= '0;
      num_rows_r      <= '0;
      cnt             <= '0;
      sram_a          <= '0;
      sram_d          <= '0;
      sfp_accum       <= 1'b0;
      sfp_passthrough <= 1'b0;
      sfp_actfunc     <= 2'b00;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);

      if (accept_c) begin
        mode_r          <= mode;
        base_r          <= base_addr;
        num_rows_r      <= num_rows;
        cnt             <= '0;
        sram_a          <= base_addr;
        sfp_accum       <= (mode == 2'd0);
        sfp_passthrough <= (mode == 2'd3);
        sfp_actfunc     <= (mode == 2'd2) ? 2'b01 : 2'b00;
      end

      if (state == CAPTURE) begin
        sram_d <= row_bw'(sfp_out);
      end

      // Address wraps modulo 2^addr_bw by truncation
      if ((state == WRITE) && !last_row_c) begin
        cnt    <= cnt + len_bw'(1);
        sram_a <= base_r + addr_bw'(cnt + len_bw'(1));
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback_ctrl.sv
// Directed bench for psum_writeback_ctrl with SRAM, OFIFO and SFP models and a write scoreboard.
module tb_psum_writeback_ctrl;

  localparam int unsigned psum_bw = 16;
  localparam int unsigned col     = 8;
  localparam int unsigned addr_bw = 11;
  localparam int unsigned len_bw  = 11;
  localparam int unsigned row_bw  = col * psum_bw;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [1:0]          mode;
  logic [addr_bw-1:0]  base_addr;
  logic [len_bw-1:0]   num_rows;
  logic                ofifo_valid;
  logic                ofifo_rd;
  logic                sram_cen;
  logic                sram_wen;
  logic [addr_bw-1:0]  sram_a;
  logic [row_bw-1:0]   sram_d;
  logic                sfp_accum;
  logic                sfp_passthrough;
  logic [1:0]          sfp_actfunc;
  logic [row_bw-1:0]   sfp_out;
  logic                busy;
  logic                done;

  psum_writeback_ctrl #(
    .psum_bw(psum_bw), .col(col), .addr_bw(addr_bw), .len_bw(len_bw)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .num_rows(num_rows), .ofifo_valid(ofifo_valid),
    .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sfp_accum(sfp_accum),
    .sfp_passthrough(sfp_passthrough), .sfp_actfunc(sfp_actfunc),
    .sfp_out(sfp_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int start_cyc  = 0;
  int done_cnt   = 0;
  int acc_cnt    = 0;
  int pop_idx    = 0;

  typedef struct {
    logic [addr_bw-1:0] a;
    logic [row_bw-1:0]  d;
  } wr_t;
  wr_t sb[$];

  function automatic logic [row_bw-1:0] rep(input logic [15:0] v);
    return {col{v}};
  endfunction

  // Initial PSUM SRAM contents for the addresses the bench reads
  function automatic logic [row_bw-1:0] init_row(input logic [addr_bw-1:0] a);
    case (a)
      11'd5:   return rep(16'd3);
      11'd6:   return rep(16'd10);
      11'd20:  return rep(16'd100);
      11'd21:  return rep(16'hFFFF);
      11'd40:  return 128'h0000_0000_0000_0000_0000_FFC0_0050_FF80;
      11'd60:  return rep(16'd1);
      11'd61:  return rep(16'd1);
      default: return '0;
    endcase
  endfunction

  // OFIFO rows in pop order
  function automatic logic [row_bw-1:0] fifo_row(input int k);
    case (k)
      0:       return rep(16'd4);
      1:       return rep(16'd1);
      2:       return rep(16'd5);
      3:       return rep(16'd2);
      4:       return rep(16'hA5A5);
      5:       return 128'h0008_0007_0006_0005_0004_0003_0002_0001;
      6:       return rep(16'd2);
      7:       return rep(16'd9);
      8:       return rep(16'h1234);
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] sfp_lane(input logic [15:0] q, input logic [15:0] f,
                                           input logic acc, input logic pass,
                                           input logic [1:0] act);
    if (pass) return f;
    if (acc) return q + f;
    if (!q[15]) return q;
    if (act == 2'b01) return 16'($signed(q) >>> 6);
    return 16'h0000;
  endfunction

  logic [row_bw-1:0] mem [2048];
  bit                written [2048];
  logic [row_bw-1:0] sram_q     = '0;
  logic [row_bw-1:0] ofifo_data = '0;

  // SRAM with 1-cycle read latency and OFIFO with data on the cycle after a pop
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        mem[sram_a]     <= sram_d;
        written[sram_a] <= 1'b1;
      end else begin
        sram_q <= written[sram_a] ? mem[sram_a] : init_row(sram_a);
      end
    end
    if (ofifo_rd) begin
      ofifo_data <= fifo_row(pop_idx);
      pop_idx    <= pop_idx + 1;
    end
  end

  always_comb begin
    sfp_out = '0;
    for (int i = 0; i < int'(col); i++) begin
      sfp_out[i*16 +: 16] = sfp_lane(sram_q[i*16 +: 16], ofifo_data[i*16 +: 16],
                                     sfp_accum, sfp_passthrough, sfp_actfunc);
    end
  end

  task automatic check(input string name, input logic [row_bw-1:0] act,
                       input logic [row_bw-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every SRAM write is matched against the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (!sram_cen) acc_cnt++;
    if (!sram_cen && !sram_wen) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", row_bw'(sram_a), row_bw'(12'hFFF));
      end else begin
        e = sb.pop_front();
        check("wr_addr", row_bw'(sram_a), row_bw'(e.a));
        check("wr_data", sram_d, e.d);
      end
    end
  end

  task automatic push_wr(input logic [addr_bw-1:0] a, input logic [row_bw-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic start_pass(input logic [1:0] m, input logic [addr_bw-1:0] b,
                            input logic [len_bw-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; mode = m; base_addr = b; num_rows = n;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    int  waited = 0;
    bit  seen   = 1'b0;
    while (!seen && waited < 60) begin
      @(negedge clk);
      waited++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", row_bw'(0), row_bw'(1));
    end else begin
      check("done_latency", row_bw'(cyc - start_cyc), row_bw'(lat));
      check("busy_in_done", row_bw'(busy), row_bw'(1));
      @(negedge clk);
      check("done_one_cycle", row_bw'(done), row_bw'(0));
      check("busy_after_done", row_bw'(busy), row_bw'(0));
    end
  endtask

  initial begin
    int snap_pop;
    int snap_acc;
    int snap_done;

    reset = 1'b1; start = 1'b1; mode = 2'd3; base_addr = 11'd7; num_rows = 11'd4;
    ofifo_valid = 1'b1;

    // Reset and start together: reset wins
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ofifo_rd", row_bw'(ofifo_rd), row_bw'(0));
    check("rst_cen", row_bw'(sram_cen), row_bw'(1));
    check("rst_wen", row_bw'(sram_wen), row_bw'(1));
    check("rst_addr", row_bw'(sram_a), row_bw'(0));
    check("rst_data", sram_d, row_bw'(0));
    check("rst_busy", row_bw'(busy), row_bw'(0));
    check("rst_done", row_bw'(done), row_bw'(0));
    check("rst_ctrl", row_bw'({sfp_accum, sfp_passthrough, sfp_actfunc}), row_bw'(0));
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("busy_after_rst", row_bw'(busy), row_bw'(0));

    // Accumulate, two rows
    push_wr(11'd5, rep(16'd7));
    push_wr(11'd6, rep(16'd11));
    snap_pop = pop_idx;
    start_pass(2'd0, 11'd5, 11'd2);
    @(negedge clk);
    check("m0_ctrl", row_bw'({sfp_accum, sfp_passthrough, sfp_actfunc}), row_bw'(4'b1000));
    check("m0_busy", row_bw'(busy), row_bw'(1));
    wait_done(7);
    check("m0_pops", row_bw'(pop_idx - snap_pop), row_bw'(2));

    // Accumulate with a 4-cycle OFIFO stall on row 1
    push_wr(11'd20, rep(16'd105));
    push_wr(11'd21, rep(16'd1));
    snap_pop = pop_idx;
    start_pass(2'd0, 11'd20, 11'd2);
    repeat (3) begin @(posedge clk); #1; end
    ofifo_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_cen", row_bw'(sram_cen), row_bw'(1));
      check("stall_no_pop", row_bw'(ofifo_rd), row_bw'(0));
      @(posedge clk); #1;
    end
    ofifo_valid = 1'b1;
    wait_done(11);
    check("stall_pops", row_bw'(pop_idx - snap_pop), row_bw'(2));

    // Leaky ReLU never touches OFIFO
    ofifo_valid = 1'b0;
    push_wr(11'd40, 128'h0000_0000_0000_0000_0000_FFFF_0050_FFFE);
    snap_pop = pop_idx;
    start_pass(2'd2, 11'd40, 11'd1);
    @(negedge clk);
    check("m2_ctrl", row_bw'({sfp_accum, sfp_passthrough, sfp_actfunc}), row_bw'(4'b0001));
    wait_done(4);
    check("m2_no_pop", row_bw'(pop_idx - snap_pop), row_bw'(0));
    ofifo_valid = 1'b1;

    // Passthrough wrapping past the top address, with an ignored mid-pass start
    push_wr(11'd2047, rep(16'hA5A5));
    push_wr(11'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    start_pass(2'd3, 11'd2047, 11'd2);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; base_addr = 11'd100; num_rows = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(7);
    check("m3_ctrl_held", row_bw'({sfp_accum, sfp_passthrough, sfp_actfunc}), row_bw'(4'b0100));

    // Zero rows: done right away, no SRAM access
    snap_acc = acc_cnt;
    snap_pop = pop_idx;
    start_pass(2'd1, 11'd300, 11'd0);
    wait_done(1);
    check("zero_rows_access", row_bw'(acc_cnt - snap_acc), row_bw'(0));
    check("zero_rows_pops", row_bw'(pop_idx - snap_pop), row_bw'(0));

    // Reset during CAPTURE of row 1 of 3
    push_wr(11'd60, rep(16'd3));
    snap_pop = pop_idx;
    start_pass(2'd0, 11'd60, 11'd3);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", row_bw'(busy), row_bw'(0));
    check("midrst_cen", row_bw'(sram_cen), row_bw'(1));
    check("midrst_addr", row_bw'(sram_a), row_bw'(0));
    check("midrst_data", sram_d, row_bw'(0));
    check("midrst_pops", row_bw'(pop_idx - snap_pop), row_bw'(2));
    snap_acc  = acc_cnt;
    snap_pop  = pop_idx;
    snap_done = done_cnt;
    repeat (10) @(negedge clk);
    check("midrst_no_access", row_bw'(acc_cnt - snap_acc), row_bw'(0));
    check("midrst_no_pop", row_bw'(pop_idx - snap_pop), row_bw'(0));
    check("midrst_no_done", row_bw'(done_cnt - snap_done), row_bw'(0));

    // Fresh pass after reset
    push_wr(11'd70, rep(16'h1234));
    start_pass(2'd3, 11'd70, 11'd1);
    wait_done(4);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", row_bw'(sb.size()), row_bw'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/psum_writeback_ctrl.md
Name: psum_writeback_ctrl

Overview:
- Sequences the read-modify-write loop around a row of `col` SFP lanes.
- For each output row it pops one OFIFO row and reads the matching PSUM SRAM word. It then drives the shared SFP control (accum/actFunc/passthrough), captures the SFP result, and writes it back to the same SRAM address.
- Sits between OFIFO, the PSUM SRAM macro (active-low CEN/WEN, 1-cycle read latency) and the SFP lanes. It is the initiator side of the SFP's psum_in/ofifo_in -> sfp_out interface.

Parameters:
- psum_bw, 16, width of one psum lane.
- col, 8, number of SFP lanes / psum words per SRAM row.
- addr_bw, 11, PSUM SRAM address width.
- len_bw, 11, width of the row-count input.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a pass; ignored unless idle.
- mode  input  2  pass type: 0 accumulate, 1 ReLU, 2 leaky ReLU, 3 passthrough (overwrite with OFIFO).
- base_addr  input  addr_bw  first SRAM row of the pass.
- num_rows  input  len_bw  rows to process.
- ofifo_valid  input  1  OFIFO holds at least one full row.
- ofifo_rd  output  1  pop one OFIFO row; data valid on the following cycle.
- sram_cen  output  1  SRAM chip enable, active low.
- sram_wen  output  1  SRAM write enable, active low.
- sram_a  output  addr_bw  SRAM address.
- sram_d  output  col*psum_bw  SRAM write data.
- sfp_accum  output  1  to all SFP lanes.
- sfp_passthrough  output  1  to all SFP lanes.
- sfp_actfunc  output  2  to all SFP lanes.
- sfp_out  input  col*psum_bw  concatenated SFP results (combinational from SRAM Q and OFIFO data).
- busy  output  1  high from the cycle after an accepted start through DONE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset values: state IDLE, row counter 0, ofifo_rd 0, sram_cen 1, sram_wen 1, sram_a 0, sram_d 0, busy 0, done 0. Control registers are cleared, so sfp_accum=0, sfp_passthrough=0, sfp_actfunc=00.
- Reset mid-pass: next cycle is IDLE with the reset values above. No done pulse; a write in flight is dropped.
- Start is accepted only when start=1 in IDLE.
  - Acceptance latches mode, base_addr and num_rows; row counter cnt=0.
  - If num_rows==0, go directly to DONE.
  - Otherwise go to ISSUE.
- start outside IDLE is ignored.
- SFP control is registered from the latched mode and held stable for the whole pass:
  - mode 0: accum=1, passthrough=0, actfunc=00.
  - mode 1: accum=0, passthrough=0, actfunc=00.
  - mode 2: accum=0, passthrough=0, actfunc=01.
  - mode 3: passthrough=1, accum=0, actfunc=00.
- needs_fifo = (mode==0 || mode==3). Modes 1 and 2 never assert ofifo_rd.
- ISSUE:
  - If needs_fifo and !ofifo_valid: stall in ISSUE with cen=1, ofifo_rd=0.
  - Otherwise, for exactly one cycle: cen=0, wen=1, sram_a=base+cnt, ofifo_rd=needs_fifo. Then go to CAPTURE.
- CAPTURE:
  - SRAM Q and OFIFO data are valid this cycle; cen=1, ofifo_rd=0.
  - sfp_out is registered into sram_d at the end of the cycle. Go to WRITE.
- WRITE:
  - cen=0, wen=0, sram_a=base+cnt, sram_d holds the captured row.
  - If cnt==num_rows-1, go to DONE; else cnt++ and go to ISSUE.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Throughput: 3 cycles per row with no stalls, so a pass takes 3*num_rows+1 cycles from start acceptance to the done pulse.
- Address arithmetic is modulo 2^addr_bw: base+cnt wraps past the top of SRAM with no error.
- OFIFO pops occur only in ISSUE. One pop per row exactly; never two pops without an intervening write.
- A single SRAM port is time-multiplexed: the controller never issues a read and a write in the same cycle.
- sram_d is only updated in CAPTURE and holds its value otherwise.

Test Plan:
- Reset and start both high -> reset wins. Outputs at reset values, and busy stays 0 the next cycle.
- Mode 0, base=5, num_rows=2, ofifo_valid=1, SRAM[5]=row of 3, OFIFO row of 4, sfp_out modelled by SFP -> SRAM[5] written with all-7 lanes.
  - ofifo_rd pulses twice.
  - done pulses exactly 7 cycles after start.
- Mode 0 with ofifo_valid low for 4 cycles during row 1 -> controller holds ISSUE with cen=1 and no pop. Row completes 4 cycles late with correct data.
- Mode 2, num_rows=1, SRAM word lane0=0xFF80 -> sfp_actfunc=01, ofifo_rd never asserted. SRAM written with the leaky result 0xFFFE in lane0.
- Mode 3, base=2^addr_bw-1, num_rows=2 -> writes go to the last address then address 0, each with the OFIFO data.
  - A start pulse mid-pass is ignored.
  - num_rows=0 gives a done pulse 1 cycle after start with no SRAM access.
- Reset asserted in CAPTURE of row 1 of 3 -> no further SRAM writes or pops, no done pulse. A fresh start afterwards completes normally.
